// File: rtl/apb_bridge_ctrl.sv
// AHB-Lite slave to APB master bridge: one AHB transfer becomes one APB SETUP/ACCESS transfer.
// Latency: accept in cycle N, zero-wait completion (HREADYOUT=1) in N+4; +1 per PREADY=0 cycle.
// Backpressure: AHB data phase is stretched via HREADYOUT; APB stalls via PREADY, optionally bounded.
module apb_bridge_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Last ACCESS count before giving up; only meaningful when the timeout is enabled.
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  localparam bit          TMO_EN   = (TMO_CYC != 0);

  state_t      state;
  logic [15:0] tmo_cnt;
  // Registered control outputs, packed as {HREADYOUT, HRESP, PSEL, PENABLE}.
  logic [3:0]  ctl;

  logic   accept;
  logic   addr_zero;
  logic   tmo_hit;
  state_t accept_nxt;
  logic   unused;

  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign addr_zero  = (HADDR == '0);
  // A zero address is answered with ERROR without ever touching the APB side.
  assign accept_nxt = addr_zero ? ST_ERR1 : ST_LATCH;
  assign tmo_hit    = TMO_EN && (tmo_cnt == TMO_LAST);
  // HTRANS[0] only separates NONSEQ from SEQ and IDLE from BUSY; neither matters here.
  assign unused     = HTRANS[0];

  assign {HREADYOUT, HRESP, PSEL, PENABLE} = ctl;

  // Control output pattern that belongs to each state, loaded together with the state.
  function automatic logic [3:0] enc(input state_t s);
    case (s)
      ST_IDLE:   enc = 4'b1000;
      ST_LATCH:  enc = 4'b0000;
      ST_SETUP:  enc = 4'b0010;
      ST_ACCESS: enc = 4'b0011;
      ST_RESP:   enc = 4'b1000;
      ST_ERR1:   enc = 4'b0100;
      ST_ERR2:   enc = 4'b1100;
      default:   enc = 4'b1000;
    endcase
  endfunction

  // Transfer sequencer: state, registered control outputs, APB request and AHB read data.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      ctl     <= enc(ST_IDLE);
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      HRDATA  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP, ST_ERR2: begin
          if (accept) begin
            PADDR  <= HADDR;
            PWRITE <= HWRITE;
            state  <= accept_nxt;
            ctl    <= enc(accept_nxt);
          end else begin
            state <= ST_IDLE;
            ctl   <= enc(ST_IDLE);
          end
        end
        ST_LATCH: begin
          // Write data arrives in the AHB data phase, one cycle after the address.
          if (PWRITE) begin
            PWDATA <= HWDATA;
          end
          state <= ST_SETUP;
          ctl   <= enc(ST_SETUP);
        end
        ST_SETUP: begin
          tmo_cnt <= '0;
          state   <= ST_ACCESS;
          ctl     <= enc(ST_ACCESS);
        end
        ST_ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) begin
              state <= ST_ERR1;
              ctl   <= enc(ST_ERR1);
            end else begin
              if (!PWRITE) begin
                HRDATA <= PRDATA;
              end
              state <= ST_RESP;
              ctl   <= enc(ST_RESP);
            end
          end else if (tmo_hit) begin
            state <= ST_ERR1;
            ctl   <= enc(ST_ERR1);
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_ERR1: begin
          state <= ST_ERR2;
          ctl   <= enc(ST_ERR2);
        end
        default: begin
          state <= ST_IDLE;
          ctl   <= enc(ST_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
module tb_apb_bridge_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  // Single-slave bus: the bus ready is this slave's own ready.
  assign HREADY = HREADYOUT;

  apb_bridge_ctrl #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO)) dut (
    .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hrdata = 32'h0;

  // Parameters of the transfer currently owned by the APB slave model.
  logic [31:0] cur_addr = 32'h0;
  logic        cur_wr = 1'b0;
  logic [31:0] cur_wd = 32'h0;
  int          cur_wait = 0;
  logic        cur_err = 1'b0;
  logic [31:0] cur_prdata = 32'h0;
  int          cur_n = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h want=%h at cycle %0d", name, got, want, cyc);
    end
  endtask

  // One AHB transfer: optional idle/noise cycles, wait for ready, address phase, data phase.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int wt, input logic se, input logic [31:0] rd, input int gap);
    int   n;
    exp_t e;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      case ($urandom_range(0, 2))
        0:       begin HSEL = 1'b1; HTRANS = 2'b00; end
        1:       begin HSEL = 1'b1; HTRANS = 2'b01; end
        default: begin HSEL = 1'b0; HTRANS = 2'b10; end
      endcase
      HADDR  = $urandom;
      HWRITE = 1'($urandom);
      HWDATA = $urandom;
    end
    @(negedge clk);
    n = 0;
    while (!HREADYOUT && n < 60) begin
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      @(negedge clk);
      n++;
    end
    if (!HREADYOUT) chk("accept_wait", HREADYOUT, 1);
    cur_addr   = addr;
    cur_wr     = wr;
    cur_wd     = wd;
    cur_wait   = wt;
    cur_err    = se;
    cur_prdata = rd;
    cur_n      = cyc;
    // Reference model: completion cycle and response from the transfer's own parameters.
    e.cyc = cyc;
    if (addr == 32'h0) begin
      e.err = 1'b1; e.cyc = cyc + 2;
    end else if (wt >= TMO) begin
      e.err = 1'b1; e.cyc = cyc + 4 + TMO;
    end else if (se) begin
      e.err = 1'b1; e.cyc = cyc + 5 + wt;
    end else begin
      e.err = 1'b0; e.cyc = cyc + 4 + wt;
      if (!wr) m_hrdata = rd;
    end
    e.rdata = m_hrdata;
    q.push_back(e);
    HSEL   = 1'b1;
    HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    HADDR  = addr;
    HWRITE = wr;
    HWDATA = $urandom;
    @(negedge clk);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = $urandom;
    HWRITE = 1'($urandom);
    HWDATA = wd;
  endtask

  // Monitor: pops the next expectation whenever a stretched data phase ends.
  initial begin : monitor
    logic prev_ro;
    logic prev_resp;
    exp_t e;
    prev_ro   = 1'b1;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!HRESET) begin
        if (HREADYOUT && !prev_ro) begin
          if (q.size() == 0) begin
            chk("unexpected_done", HREADYOUT, 0);
          end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("hresp", HRESP, e.err);
            chk("hresp_first", prev_resp, e.err);
            chk("hrdata", HRDATA, e.rdata);
            chk("apb_idle_at_done", {PSEL, PENABLE}, 0);
          end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
          chk("late_done", cyc, q[0].cyc);
          void'(q.pop_front());
        end
      end
      prev_ro   = HREADYOUT;
      prev_resp = HRESP;
    end
  end

  // APB slave model: checks the request and answers after cur_wait stalled ACCESS cycles.
  initial begin : apb_slave
    int   acc;
    logic rdy;
    acc     = 0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    forever begin
      @(negedge clk);
      if (!HRESET && cur_addr == 32'h0) chk("psel_zero_addr", PSEL, 0);
      if (!HRESET && PSEL) begin
        chk("paddr", PADDR, cur_addr);
        chk("pwrite", PWRITE, cur_wr);
        if (cur_wr) chk("pwdata", PWDATA, cur_wd);
        if (!PENABLE) chk("setup_cycle", cyc, cur_n + 2);
      end
      if (PSEL && PENABLE) begin
        rdy     = (acc == cur_wait);
        PREADY  = rdy;
        PSLVERR = rdy ? cur_err : 1'($urandom);
        PRDATA  = rdy ? cur_prdata : $urandom;
        acc++;
      end else begin
        acc     = 0;
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end
    end
  end

  initial begin : stim
    int          n;
    logic [31:0] a;
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_hrdata", HRDATA, 0);
    HRESET = 1'b0;

    // Directed cases: zero-wait write, stalled read, slave error, zero address, timeout.
    do_xfer(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 2);
    do_xfer(32'h4000_0004, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1);
    do_xfer(32'h4000_0020, 1'b1, 32'hCAFE_0001, 1, 1'b1, 32'h0, 0);
    do_xfer(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1);
    do_xfer(32'h4000_0030, 1'b1, 32'h5555_AAAA, 100, 1'b0, 32'h0, 1);
    // Back-to-back transfers accepted in the response cycle, including an erroring read.
    do_xfer(32'h4000_0040, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 0);
    do_xfer(32'h4000_0044, 1'b0, 32'h0, 2, 1'b1, 32'h7777_7777, 0);
    do_xfer(32'h4000_0048, 1'b1, 32'h0102_0304, 0, 1'b0, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h0;
      else if (a == 32'h0) a = 32'h1;
      do_xfer(a, 1'($urandom), $urandom, $urandom_range(0, 6),
              ($urandom_range(0, 5) == 0), $urandom, $urandom_range(0, 2));
    end

    // Reset in the middle of an ACCESS phase abandons the transfer.
    do_xfer(32'h4000_0100, 1'b0, 32'h0, 3, 1'b0, 32'hAAAA_5555, 0);
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("penable_wait", PENABLE, 1);
    @(negedge clk);
    HRESET   = 1'b1;
    q.delete();
    m_hrdata = 32'h0;
    HSEL     = 1'b1;
    HTRANS   = 2'b10;
    HADDR    = 32'h4000_0200;
    @(negedge clk);
    chk("mid_rst_hreadyout", HREADYOUT, 1);
    chk("mid_rst_hresp", HRESP, 0);
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_pwrite", PWRITE, 0);
    chk("mid_rst_paddr", PADDR, 0);
    chk("mid_rst_pwdata", PWDATA, 0);
    chk("mid_rst_hrdata", HRDATA, 0);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    @(negedge clk);
    HRESET = 1'b0;
    do_xfer(32'h4000_0300, 1'b0, 32'h0, 0, 1'b0, 32'h600D_600D, 1);

    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
